char_ground_detect: RTL



---
 rtl/char_ground_detect.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/char_ground_detect.sv
// char_ground_detect
// Collision responder for the player character. Once per frame it snapshots
// the character's top-left corner, scans an 8-entry platform ROM one entry
// per clock, and reports the landing level below the character together with
// whether the feet currently rest on it.
module char_ground_detect #(
  parameter int CHAR_LNG = 32,
  parameter int CHAR_HGT = 64,
  parameter int GROUND_Y = 700,
  parameter int TOL      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [11:0] pos_x,
  input  logic [11:0] pos_y,
  output logic        on_ground,
  output logic [11:0] ground_y,
  output logic        result_valid,
  output logic        busy
);

  // Parameter values at the widths the datapath works in.
  localparam logic [11:0] GROUND_Y_C = 12'(GROUND_Y);
  localparam logic [12:0] GROUND_13  = 13'(GROUND_Y);
  localparam logic [12:0] TOL_13     = 13'(TOL);
  localparam logic [12:0] HGT_13     = 13'(CHAR_HGT);
  localparam logic [12:0] LNG_13     = 13'(CHAR_LNG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [11:0] x_start;
    logic [11:0] x_end;    // exclusive
    logic [11:0] y_top;
    logic        valid;
  } plat_t;

  // Fixed platform table; unused slots are marked invalid.
  function automatic plat_t plat_rom(input logic [2:0] idx);
    plat_t p;
    case (idx)
      3'd0:    p = '{x_start: 12'd100, x_end: 12'd300, y_top: 12'd600, valid: 1'b1};
      3'd1:    p = '{x_start: 12'd400, x_end: 12'd600, y_top: 12'd500, valid: 1'b1};
      3'd2:    p = '{x_start: 12'd700, x_end: 12'd900, y_top: 12'd400, valid: 1'b1};
      3'd3:    p = '{x_start: 12'd200, x_end: 12'd400, y_top: 12'd300, valid: 1'b1};
      default: p = '{x_start: 12'd0,   x_end: 12'd0,   y_top: 12'd0,   valid: 1'b0};
    endcase
    return p;
  endfunction

  // Registered state
  state_t      state_r;
  logic [2:0]  idx_r;
  logic [11:0] best_r;
  logic [12:0] feet_r;
  logic [12:0] right_r;
  logic [11:0] left_r;
  logic        on_ground_r;
  logic [11:0] ground_y_r;
  logic        result_valid_r;
  logic        busy_r;

  // Next-state values
  state_t      state_s;
  logic [2:0]  idx_s;
  logic [11:0] best_s;
  logic [12:0] feet_s;
  logic [12:0] right_s;
  logic [11:0] left_s;
  logic        on_ground_s;
  logic [11:0] ground_y_s;
  logic        result_valid_s;
  logic        busy_s;

  // Entry evaluation helpers
  plat_t       entry_s;
  logic        cand_s;
  logic        stand_s;

  // Decide whether the current ROM entry lies under the snapshot and could be landed on.
  always_comb begin
    entry_s = plat_rom(idx_r);
    cand_s  = entry_s.valid
            && ({1'b0, entry_s.x_start} < right_r)
            && (left_r < entry_s.x_end)
            && (({1'b0, entry_s.y_top} + TOL_13) >= feet_r);
  end

  // Feet within TOL below the chosen level, or at/below the floor, count as standing.
  always_comb begin
    stand_s = ((feet_r >= {1'b0, best_r}) && (feet_r <= ({1'b0, best_r} + TOL_13)))
            || (feet_r >= GROUND_13);
  end

  // Next-state and datapath update for the scan sequencer.
  always_comb begin
    state_s        = state_r;
    idx_s          = idx_r;
    best_s         = best_r;
    feet_s         = feet_r;
    right_s        = right_r;
    left_s         = left_r;
    on_ground_s    = on_ground_r;
    ground_y_s     = ground_y_r;
    result_valid_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (frame_tick) begin
          feet_s  = {1'b0, pos_y} + HGT_13;
          right_s = {1'b0, pos_x} + LNG_13;
          left_s  = pos_x;
          idx_s   = 3'd0;
          best_s  = GROUND_Y_C;
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        // Strict compare keeps the earlier entry on equal heights.
        if (cand_s && (entry_s.y_top < best_r)) begin
          best_s = entry_s.y_top;
        end else begin
          best_s = best_r;
        end
        idx_s = idx_r + 3'd1;
        if (idx_r == 3'd7) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        ground_y_s     = best_r;
        on_ground_s    = stand_s;
        result_valid_s = 1'b1;
        state_s        = IDLE;
      end
      default: begin
        state_s = IDLE;
        idx_s   = 3'd0;
        best_s  = GROUND_Y_C;
      end
    endcase

    busy_s = (state_s == SCAN) || (state_s == DONE);
  end

  // State, snapshot and output registers; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      idx_r          <= 3'd0;
      best_r         <= GROUND_Y_C;
      feet_r         <= 13'd0;
      right_r        <= 13'd0;
      left_r         <= 12'd0;
      on_ground_r    <= 1'b0;
      ground_y_r     <= GROUND_Y_C;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      best_r         <= best_s;
      feet_r         <= feet_s;
      right_r        <= right_s;
      left_r         <= left_s;
      on_ground_r    <= on_ground_s;
      ground_y_r     <= ground_y_s;
      result_valid_r <= result_valid_s;
      busy_r         <= busy_s;
    end
  end

  assign on_ground    = on_ground_r;
  assign ground_y     = ground_y_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;

endmodule
